edge_packer: RTL

EDGE_PACKER -- requirements
Module: edge_packer

---
 rtl/edge_packer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/edge_packer.sv
// Binarizes gradient samples against a runtime threshold and packs them LSB-first into bytes held in an output FIFO.
// Optional per-frame edge pixel counter is built when EDGE_COUNT_EN is defined.
module edge_packer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] gradient,
    input  logic        gradient_valid,
    input  logic [10:0] threshold,
    input  logic        frame_start,
    output logic [7:0]  edge_byte,
    output logic        edge_valid,
    input  logic        edge_ready,
    output logic        overflow,
    output logic [11:0] edge_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [2:0]    pos_q, pos_d;
    logic [6:0]    partial_q, partial_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          edge_bit;
    logic [2:0]    pos_base;
    logic [6:0]    partial_base;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic [7:0]    push_byte;

    // frame_start restarts the group first so a coinciding sample lands in bit 0.
    always_comb begin
        edge_bit     = (gradient > threshold);
        pos_base     = frame_start ? 3'd0 : pos_q;
        partial_base = frame_start ? 7'd0 : partial_q;
        pos_d        = pos_base;
        partial_d    = partial_base;
        push         = 1'b0;
        push_byte    = {edge_bit, partial_base};
        if (gradient_valid) begin
            if (pos_base == 3'd7) begin
                push      = 1'b1;
                pos_d     = 3'd0;
                partial_d = 7'd0;
            end else begin
                partial_d = partial_base | (7'(edge_bit) << pos_base);
                pos_d     = pos_base + 3'd1;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full       = (count_q == FULL_CNT);
        pop        = (count_q != '0) && edge_ready;
        push_ok    = push && (!full || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = frame_start ? 1'b0 : overflow_q;
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q      <= 3'd0;
            partial_q  <= 7'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            partial_q  <= partial_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    assign edge_valid = (count_q != '0);
    assign edge_byte  = edge_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow   = overflow_q;

`ifdef EDGE_COUNT_EN
    logic [11:0] edge_count_q, edge_count_d;
    logic [11:0] edge_count_base;

    always_comb begin
        edge_count_base = frame_start ? 12'h000 : edge_count_q;
        edge_count_d    = edge_count_base;
        if (gradient_valid && edge_bit && (edge_count_base != 12'hFFF)) begin
            edge_count_d = edge_count_base + 12'h001;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count_q <= 12'h000;
        end else begin
            edge_count_q <= edge_count_d;
        end
    end

    assign edge_count = edge_count_q;
`else
    assign edge_count = 12'h000;
`endif

endmodule
